// File: rtl/fb_rect_writer_if.sv
// Command handshake and frame-buffer port of the rectangle engine.
// master = command issuer / frame-buffer owner, slave = the engine.
interface fb_rect_writer_if;
   logic       req_valid;
   logic       req_ready;
   logic [8:0] req_x;
   logic [7:0] req_y;
   logic [8:0] req_w;
   logic [7:0] req_h;
   logic [1:0] req_op;
   logic       busy;
   logic       done;
   logic [8:0] fb_x;
   logic [7:0] fb_y;
   logic       fb_read_en;
   logic       fb_write_en;
   logic       fb_write_value;
   logic       fb_read_value;

   modport master (
      output req_valid, req_x, req_y, req_w, req_h, req_op, fb_read_value,
      input  req_ready, busy, done, fb_x, fb_y, fb_read_en, fb_write_en, fb_write_value
   );

   modport slave (
      input  req_valid, req_x, req_y, req_w, req_h, req_op, fb_read_value,
      output req_ready, busy, done, fb_x, fb_y, fb_read_en, fb_write_en, fb_write_value
   );
endinterface

// File: rtl/fb_rect_writer.sv
// Rectangle clear/set/invert engine for the 1-bit frame buffer, with clipping.
//
// state  | meaning
// IDLE   | waiting for a command, req_ready high
// FILL   | one clear/set write per cycle
// RD     | invert: read current pixel
// WR     | invert: write inverted read data to the same pixel
// DONE   | one-cycle done pulse
module fb_rect_writer #(
   parameter int WIDTH  = 320,
   parameter int HEIGHT = 200
) (
   input logic           clk,
   input logic           rst_n,
   fb_rect_writer_if.slave bus
);
   typedef enum logic [2:0] {S_IDLE, S_FILL, S_RD, S_WR, S_DONE} state_t;

   localparam logic [9:0] X_LIM = 10'(WIDTH);
   localparam logic [8:0] Y_LIM = 9'(HEIGHT);

   state_t     state_q, state_d;
   logic [8:0] x_q, x_d, w_q, w_d, cx_q, cx_d, fb_x_q, fb_x_d;
   logic [7:0] y_q, y_d, h_q, h_d, cy_q, cy_d, fb_y_q, fb_y_d;
   logic [1:0] op_q, op_d;
   logic       rd_en_q, rd_en_d, wr_en_q, wr_en_d;
   logic       wr_val_q, wr_val_d, wr_inv_q, wr_inv_d;
   logic       done_q, done_d, busy_q, busy_d, ready_q, ready_d;
   logic       last, issue_rd, issue_wr, in_bounds;
   logic [9:0] x_abs;
   logic [8:0] y_abs;

   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      y_d      = y_q;
      w_d      = w_q;
      h_d      = h_q;
      op_d     = op_q;
      cx_d     = cx_q;
      cy_d     = cy_q;
      fb_x_d   = fb_x_q;
      fb_y_d   = fb_y_q;
      wr_val_d = wr_val_q;
      rd_en_d  = 1'b0;
      wr_en_d  = 1'b0;
      wr_inv_d = 1'b0;
      done_d   = 1'b0;
      issue_rd = 1'b0;
      issue_wr = 1'b0;
      last     = (cx_q == w_q - 9'd1) && (cy_q == h_q - 8'd1);

      case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               x_d  = bus.req_x;
               y_d  = bus.req_y;
               w_d  = bus.req_w;
               h_d  = bus.req_h;
               op_d = bus.req_op;
               cx_d = 9'd0;
               cy_d = 8'd0;
               if (bus.req_w == 9'd0 || bus.req_h == 8'd0) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else if (bus.req_op[1]) begin
                  state_d  = S_RD;
                  issue_rd = 1'b1;
               end else begin
                  state_d  = S_FILL;
                  issue_wr = 1'b1;
                  wr_val_d = bus.req_op[0];
               end
            end
         end
         S_FILL, S_WR: begin
            if (last) begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end else begin
               if (cx_q == w_q - 9'd1) begin
                  cx_d = 9'd0;
                  cy_d = cy_q + 8'd1;
               end else begin
                  cx_d = cx_q + 9'd1;
               end
               state_d  = (state_q == S_WR) ? S_RD : S_FILL;
               issue_rd = (state_q == S_WR);
               issue_wr = (state_q == S_FILL);
            end
         end
         S_RD: begin
            state_d  = S_WR;
            issue_wr = 1'b1;
            wr_inv_d = 1'b1;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Outputs are registered, so address and enables follow the pixel of the next state.
      x_abs     = {1'b0, x_d} + {1'b0, cx_d};
      y_abs     = {1'b0, y_d} + {1'b0, cy_d};
      in_bounds = (x_abs < X_LIM) && (y_abs < Y_LIM);
      if ((issue_rd || issue_wr) && in_bounds) begin
         fb_x_d  = x_abs[8:0];
         fb_y_d  = y_abs[7:0];
         rd_en_d = issue_rd;
         wr_en_d = issue_wr;
      end
      busy_d  = (state_d != S_IDLE);
      ready_d = (state_d == S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         x_q      <= '0;
         y_q      <= '0;
         w_q      <= '0;
         h_q      <= '0;
         op_q     <= '0;
         cx_q     <= '0;
         cy_q     <= '0;
         fb_x_q   <= '0;
         fb_y_q   <= '0;
         rd_en_q  <= 1'b0;
         wr_en_q  <= 1'b0;
         wr_val_q <= 1'b0;
         wr_inv_q <= 1'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
         ready_q  <= 1'b1;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         w_q      <= w_d;
         h_q      <= h_d;
         op_q     <= op_d;
         cx_q     <= cx_d;
         cy_q     <= cy_d;
         fb_x_q   <= fb_x_d;
         fb_y_q   <= fb_y_d;
         rd_en_q  <= rd_en_d;
         wr_en_q  <= wr_en_d;
         wr_val_q <= wr_val_d;
         wr_inv_q <= wr_inv_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
         ready_q  <= ready_d;
      end
   end

   assign bus.req_ready   = ready_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.fb_x        = fb_x_q;
   assign bus.fb_y        = fb_y_q;
   assign bus.fb_read_en  = rd_en_q;
   assign bus.fb_write_en = wr_en_q;
   // Read data only arrives during the WR cycle, so the inverted value cannot be registered.
   assign bus.fb_write_value = wr_inv_q ? ~bus.fb_read_value : wr_val_q;
endmodule

// File: tb/tb_fb_rect_writer.sv
// Bench for fb_rect_writer: directed table, hand sequences and random commands
// against a pixel-list reference model and a frame-buffer memory model.
module tb_fb_rect_writer;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fb_rect_writer_if bus ();
   fb_rect_writer #(.WIDTH(320), .HEIGHT(200)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   typedef struct {
      logic rd, wr, val;
      int   x, y;
      logic done, busy, ready;
   } cyc_t;

   typedef struct {
      logic [1:0] op;
      int x, y, w, h, done_c, nwr, nrd;
   } vec_t;

   int checks = 0;
   int passed = 0;
   bit fb_mem  [0:199][0:319];
   bit ref_mem [0:199][0:319];
   logic s_rd, s_wr, s_val, s_done, s_busy, s_ready;
   logic [8:0] s_x;
   logic [7:0] s_y;
   bit pend_rd = 1'b0;
   bit rd_next = 1'b0;
   int exp_lx = 0;
   int exp_ly = 0;
   int cmd_id = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
   endtask

   function automatic logic [22:0] pack(input logic rd, wr, val, input logic [8:0] x,
                                        input logic [7:0] y, input logic dn, bz, rdy);
      return {rd, wr, val, x, y, dn, bz, rdy};
   endfunction

   function automatic cyc_t mk(input logic rd, wr, val, input int x, y, input logic dn, bz, rdy);
      cyc_t e;
      e.rd = rd; e.wr = wr; e.val = val; e.x = x; e.y = y;
      e.done = dn; e.busy = bz; e.ready = rdy;
      return e;
   endfunction

   // One clock: registered read data lands just after the edge, outputs sampled mid-cycle.
   task automatic step();
      @(posedge clk);
      #1;
      if (pend_rd) begin
         bus.fb_read_value = rd_next;
         pend_rd = 1'b0;
      end
      @(negedge clk);
      s_rd = bus.fb_read_en;   s_wr = bus.fb_write_en; s_val = bus.fb_write_value;
      s_x = bus.fb_x;          s_y = bus.fb_y;
      s_done = bus.done;       s_busy = bus.busy;      s_ready = bus.req_ready;
      if (s_rd) begin
         pend_rd = 1'b1;
         rd_next = (s_x < 320 && s_y < 200) ? fb_mem[s_y][s_x] : 1'b0;
      end
      if (s_wr && s_x < 320 && s_y < 200) fb_mem[s_y][s_x] = s_val;
   endtask

   task automatic mem_check(input string name);
      int mism = 0;
      for (int yy = 0; yy < 200; yy++)
         for (int xx = 0; xx < 320; xx++)
            if (fb_mem[yy][xx] != ref_mem[yy][xx]) mism++;
      check(name, mism, 0);
   endtask

   task automatic run_cmd(input logic [1:0] op, input int x, y, w, h,
                          output int done_c, nwr, nrd);
      cyc_t q[$];
      cyc_t e;
      int cx, cy, xa, ya, g;
      logic inb, v;
      cmd_id++;
      for (int k = 0; k < w * h; k++) begin
         cx = k % w;  cy = k / w;
         xa = x + cx; ya = y + cy;
         inb = (xa < 320) && (ya < 200);
         if (inb) begin exp_lx = xa; exp_ly = ya; end
         v = 1'b0;
         if (inb) v = op[1] ? ~ref_mem[ya][xa] : op[0];
         if (op[1]) begin
            q.push_back(mk(inb, 1'b0, 1'b0, exp_lx, exp_ly, 1'b0, 1'b1, 1'b0));
            q.push_back(mk(1'b0, inb, v, exp_lx, exp_ly, 1'b0, 1'b1, 1'b0));
         end else begin
            q.push_back(mk(1'b0, inb, v, exp_lx, exp_ly, 1'b0, 1'b1, 1'b0));
         end
         if (inb) ref_mem[ya][xa] = v;
      end
      q.push_back(mk(1'b0, 1'b0, 1'b0, exp_lx, exp_ly, 1'b1, 1'b1, 1'b0));
      q.push_back(mk(1'b0, 1'b0, 1'b0, exp_lx, exp_ly, 1'b0, 1'b0, 1'b1));

      g = 0;
      while (!s_ready && g < 100) begin step(); g++; end
      if (!s_ready) check($sformatf("cmd%0d ready_wait", cmd_id), s_ready, 1);
      bus.req_valid = 1'b1;
      bus.req_x = 9'(x); bus.req_y = 8'(y); bus.req_w = 9'(w); bus.req_h = 8'(h);
      bus.req_op = op;
      step();
      bus.req_valid = 1'b0;
      bus.req_x = 9'($urandom); bus.req_y = 8'($urandom);
      bus.req_w = 9'($urandom); bus.req_h = 8'($urandom); bus.req_op = 2'($urandom);
      done_c = -1; nwr = 0; nrd = 0;
      for (int c = 1; c <= q.size(); c++) begin
         if (c > 1) step();
         e = q[c-1];
         check($sformatf("cmd%0d cyc%0d {rd,wr,val,x,y,done,busy,ready}", cmd_id, c),
               pack(s_rd, s_wr, s_val & s_wr, s_x, s_y, s_done, s_busy, s_ready),
               pack(e.rd, e.wr, e.val, 9'(e.x), 8'(e.y), e.done, e.busy, e.ready));
         if (s_done && done_c < 0) done_c = c;
         if (s_wr) nwr++;
         if (s_rd) nrd++;
      end
   endtask

   vec_t tbl[10];
   int dc, nw, nr, cnt, exp_done;
   int dcs[$];
   logic [1:0] rop;
   int rx, ry, rw, rh;

   initial begin
      tbl[0] = '{2'b01,   0,   0, 1, 1,  2, 1, 0};
      tbl[1] = '{2'b10,   0,   0, 2, 1,  5, 2, 2};
      tbl[2] = '{2'b01,  10,   5, 3, 2,  7, 6, 0};
      tbl[3] = '{2'b00, 318, 199, 4, 1,  5, 2, 0};
      tbl[4] = '{2'b01,  20,  20, 0, 7,  1, 0, 0};
      tbl[5] = '{2'b01,  30,  30, 3, 0,  1, 0, 0};
      tbl[6] = '{2'b01, 400,   0, 2, 2,  5, 0, 0};
      tbl[7] = '{2'b10, 318, 198, 3, 3, 19, 4, 4};
      tbl[8] = '{2'b00, 511, 255, 1, 1,  2, 0, 0};
      tbl[9] = '{2'b11, 319, 199, 1, 1,  3, 1, 1};

      bus.req_valid = 1'b0; bus.req_x = '0; bus.req_y = '0; bus.req_w = '0;
      bus.req_h = '0; bus.req_op = '0; bus.fb_read_value = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset outputs", pack(bus.fb_read_en, bus.fb_write_en, bus.fb_write_value, bus.fb_x,
            bus.fb_y, bus.done, bus.busy, bus.req_ready), pack(0, 0, 0, 0, 0, 0, 0, 1));
      rst_n = 1'b1;
      step();

      for (int i = 0; i < 10; i++) begin
         run_cmd(tbl[i].op, tbl[i].x, tbl[i].y, tbl[i].w, tbl[i].h, dc, nw, nr);
         check($sformatf("tbl%0d done_cycle", i), dc, tbl[i].done_c);
         check($sformatf("tbl%0d writes", i), nw, tbl[i].nwr);
         check($sformatf("tbl%0d reads", i), nr, tbl[i].nrd);
         mem_check($sformatf("tbl%0d memory", i));
      end

      // Back-to-back 1x1 sets with req_valid held high across the first command.
      bus.req_valid = 1'b1; bus.req_op = 2'b01;
      bus.req_x = 9'd7; bus.req_y = 8'd7; bus.req_w = 9'd1; bus.req_h = 8'd1;
      for (int c = 1; c <= 8; c++) begin
         step();
         if (s_done) dcs.push_back(c);
         if (c == 3) check("b2b ready after done", s_ready, 1);
         if (c == 4) bus.req_valid = 1'b0;
      end
      check("b2b done count", dcs.size(), 2);
      if (dcs.size() == 2) begin
         check("b2b first done", dcs[0], 2);
         check("b2b done spacing", dcs[1] - dcs[0], 3);
      end
      ref_mem[7][7] = 1'b1; exp_lx = 7; exp_ly = 7;
      mem_check("b2b memory");

      // Reset in the middle of a 100x100 set.
      bus.req_valid = 1'b1; bus.req_op = 2'b01;
      bus.req_x = 9'd20; bus.req_y = 8'd30; bus.req_w = 9'd100; bus.req_h = 8'd100;
      cnt = 0;
      for (int c = 1; c <= 49; c++) begin
         step();
         bus.req_valid = 1'b0;
         if (s_wr) cnt++;
      end
      check("pre-reset writes", cnt, 49);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async reset outputs", pack(bus.fb_read_en, bus.fb_write_en, bus.fb_write_value,
            bus.fb_x, bus.fb_y, bus.done, bus.busy, bus.req_ready), pack(0, 0, 0, 0, 0, 0, 0, 1));
      cnt = 0;
      repeat (3) begin step(); if (s_done) cnt++; end
      check("no done under reset", cnt, 0);
      rst_n = 1'b1;
      exp_lx = 0; exp_ly = 0;
      for (int i = 0; i < 49; i++) ref_mem[30][20+i] = 1'b1;
      step();
      mem_check("reset partial memory");
      run_cmd(2'b01, 50, 60, 2, 2, dc, nw, nr);
      check("post-reset done_cycle", dc, 5);
      check("post-reset writes", nw, 4);
      mem_check("post-reset memory");

      for (int i = 0; i < 25; i++) begin
         rop = 2'($urandom_range(0, 3));
         rx = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 511) : $urandom_range(290, 325);
         ry = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 255) : $urandom_range(180, 205);
         rw = $urandom_range(0, 12);
         rh = $urandom_range(0, 6);
         run_cmd(rop, rx, ry, rw, rh, dc, nw, nr);
         exp_done = (rw * rh == 0) ? 1 : (rop[1] ? 2 : 1) * rw * rh + 1;
         check($sformatf("rnd%0d done_cycle", i), dc, exp_done);
         mem_check($sformatf("rnd%0d memory", i));
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, checks);
      $fatal(1);
   end
endmodule

// File: doc/fb_rect_writer.md
# fb_rect_writer

Rectangle drawing engine that sits between the Tetris game logic and the read/write port of the 1-bit 320x200 frame buffer. It accepts one rectangle command at a time over a valid/ready handshake. It walks the rectangle row-major and issues per-pixel clear, set or invert accesses, using a read-then-write sequence for invert. Pixels outside the screen are clipped, and a one-cycle done pulse marks completion.

## Interface
- WIDTH, 320, screen width in pixels; clip bound for x
- HEIGHT, 200, screen height in pixels; clip bound for y
- clk  in  1  single clock; also clocks the frame buffer port
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  command valid
- req_ready  out  1  engine idle, command accepted when req_valid & req_ready
- req_x  in  9  left column of the rectangle
- req_y  in  8  top row of the rectangle
- req_w  in  9  width in pixels; 0 means empty
- req_h  in  8  height in pixels; 0 means empty
- req_op  in  2  00 clear, 01 set, 1x invert
- busy  out  1  command in progress (high when not IDLE)
- done  out  1  one-cycle completion pulse
- fb_x  out  9  frame buffer column
- fb_y  out  8  frame buffer row
- fb_read_en  out  1  read enable; data returns on fb_read_value the next cycle
- fb_write_en  out  1  write enable for the current fb_x/fb_y
- fb_write_value  out  1  pixel value to write
- fb_read_value  in  1  registered read data, valid one cycle after fb_read_en

## Operation
- All inputs are captured on acceptance; req_* changes while busy are ignored.
- States:
  - IDLE: req_ready=1. On accept: if w==0 or h==0, go to DONE. Otherwise, for clear/set go to FILL; for invert go to RD.
  - FILL: one pixel per cycle. fb_write_en=1 and fb_write_value=op[0] for in-bounds pixels. After the last pixel, go to DONE.
  - RD: fb_read_en=1 at the current pixel. Go to WR.
  - WR: same address, fb_write_en=1, fb_write_value=~fb_read_value. Then go to RD for the next pixel, or to DONE after the last.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
- Traversal: column offset cx runs 0..w-1 and row offset cy runs 0..h-1; cx wraps to 0 and increments cy.
- Absolute coordinates are computed at 10 bits (x) and 9 bits (y), so the sum does not wrap.
- A pixel is clipped when x_abs ≥ WIDTH or y_abs ≥ HEIGHT.
- Clipped pixels still consume their normal cycles: 1 in FILL, 2 in RD/WR. During those cycles both enables are 0, so latency depends only on w and h.
- fb_x/fb_y carry the low 9/8 bits of the absolute coordinates. They hold the last driven value when no enable is active.
- The engine never asserts fb_read_en and fb_write_en in the same cycle.

## Timing
- Reset values: req_ready=1, busy=0, done=0, fb_read_en=0, fb_write_en=0, fb_write_value=0, fb_x=0, fb_y=0; state IDLE.
- Take acceptance as cycle 0. The first access occurs in cycle 1.
- Clear/set: accesses in cycles 1..w*h; done in cycle w*h+1; req_ready high again in cycle w*h+2.
- Invert: pixel k is read in cycle 2k+1 and written in cycle 2k+2; done in cycle 2*w*h+1.
- Empty rectangle: done in cycle 1, with no fb accesses.
- A new command may be accepted in the first cycle after done (back-to-back; no bubble beyond DONE).
- Reset asserted mid-command:
  - All state and outputs return to reset values immediately (asynchronously).
  - Pixels already written stay written.
  - No done pulse is produced.
- req_valid held high while busy has no effect until req_ready returns.

## Test plan
- Set 3x2 at (10,5) -> writes at (10,5),(11,5),(12,5),(10,6),(11,6),(12,6) in cycles 1..6, all value 1; done at cycle 7; no reads.
- Invert 2x1 at (0,0) with the model returning 1 then 0 -> reads in cycles 1 and 3; writes 0 in cycle 2 and 1 in cycle 4; done at cycle 5.
- Clear 4x1 at (318,199) -> writes only at (318,199) and (319,199); cycles 3–4 have enables low; done still at cycle 5.
- w=0, h=7 -> no fb enables; done at cycle 1; req_ready=1 at cycle 2.
- Set 100x100 with rst_n pulled low at cycle 50 -> outputs at reset values within the same cycle; no done pulse; the next command after release executes normally.
- Two back-to-back set 1x1 commands with req_valid held high -> second accept on the cycle after the first done; done pulses exactly 3 cycles apart.
